// File: rtl/lt100_lsu_pkg.sv
// Shared encodings for the Little Timmy 100 load/store unit and bus fabric.
package lt100_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_BUS     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2,
        S_ERR     = 2'd3
    } lsu_state_e;

    // Top address nibble of each fabric region.
    localparam logic [3:0] BASE_ROM  = 4'h0;
    localparam logic [3:0] BASE_RAM  = 4'h1;
    localparam logic [3:0] BASE_GPIO = 4'h2;
    localparam logic [3:0] BASE_UART = 4'h3;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lt100_lsu_lane.sv
// Byte-lane steering: byte enables, store data replication, load extract/extend.
module lt100_lsu_lane
    import lt100_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lt100_lsu.sv
// Little Timmy 100 load/store unit: request FSM and bus handshake.
// Optional REQ watchdog enabled by defining LT100_LSU_TIMEOUT_EN.
module lt100_lsu
    import lt100_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [1:0]              resp_err_code,
    output logic                    bus_enable,
    output logic                    bus_wr_en,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_err
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("lt100_lsu supports DATA_WIDTH=32 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lt100_lsu TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_e            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;
    logic [1:0]            rcode_q, rcode_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        in_req;

`ifdef LT100_LSU_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] cnt_q, cnt_d;
`endif

    lt100_lsu_lane u_lane (
        .size_i   (size_q),
        .off_i    (addr_q[1:0]),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .rdata_i  (bus_rdata),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            rcode_q  <= ERR_NONE;
`ifdef LT100_LSU_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rcode_q  <= rcode_d;
`ifdef LT100_LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Responses are registered, so they appear in the cycle after the deciding edge.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rcode_d  = rcode_q;
`ifdef LT100_LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d     = req_wr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_d  = S_ERR;
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        rerr_d   = 1'b1;
                        rcode_d  = ERR_ALIGN;
                    end else begin
                        state_d = S_REQ;
`ifdef LT100_LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    state_d  = S_RELEASE;
                    rvalid_d = 1'b1;
                    rdata_d  = wr_q ? '0 : lane_rdata;
                    rerr_d   = bus_err;
                    rcode_d  = bus_err ? ERR_BUS : ERR_NONE;
                end
`ifdef LT100_LSU_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d  = S_RELEASE;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    rcode_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            S_RELEASE: begin
                if (!bus_ready) state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_req        = (state_q == S_REQ);
    assign req_ready     = (state_q == S_IDLE) & rst_n;
    assign bus_enable    = in_req;
    assign bus_wr_en     = in_req & wr_q;
    assign bus_addr      = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus_wdata     = (in_req & wr_q) ? lane_wdata : '0;
    assign bus_be        = in_req ? lane_be : '0;
    assign resp_valid    = rvalid_q;
    assign resp_rdata    = rdata_q;
    assign resp_err      = rerr_q;
    assign resp_err_code = rcode_q;

endmodule
